// File: rtl/column_approx_mult_pipe_if.sv
// Streaming handshake bundle for the column-truncated approximate multiplier.
// The master drives operands and the downstream ready; the slave returns results.
interface column_approx_mult_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int TW = $clog2(2*WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [TW-1:0]      theta;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;
  logic [15:0]        out_count;

  modport master (
    output in_valid, x, y, theta, out_ready,
    input  in_ready, out_valid, z, out_count
  );

  modport slave (
    input  in_valid, x, y, theta, out_ready,
    output in_ready, out_valid, z, out_count
  );
endinterface

// File: rtl/column_approx_mult_pipe.sv
// Three-stage column-truncated approximate unsigned multiplier with valid/ready flow control.
// Partial-product bits in columns below theta are dropped; optional 2^(theta-1) compensation.
module column_approx_mult_pipe #(
  parameter int WIDTH   = 8,
  parameter bit COMP_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  column_approx_mult_pipe_if.slave bus
);
  localparam int TW   = $clog2(2*WIDTH);
  localparam int SW   = 2*WIDTH + 1;
  localparam int HALF = WIDTH / 2;

  logic en;

  logic             v1;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic [TW-1:0]    th1;

  logic             v2;
  logic [SW-1:0]    sum0;
  logic [SW-1:0]    sum1;
  logic [TW-1:0]    th2;

  logic               out_valid_r;
  logic [2*WIDTH-1:0] z_r;
  logic [15:0]        count_r;

  logic [SW-1:0]      sum0_c;
  logic [SW-1:0]      sum1_c;
  logic [SW-1:0]      comp_c;
  logic [SW-1:0]      total_c;
  logic [2*WIDTH-1:0] z_c;

  // One enable for every stage: the pipe only moves when the output slot frees up.
  assign en            = ~out_valid_r | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_r;
  assign bus.z         = z_r;
  assign bus.out_count = count_r;

  always_comb begin
    logic [SW-1:0] row;
    sum0_c = '0;
    sum1_c = '0;
    row    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row = '0;
      for (int k = 0; k < WIDTH; k++) begin
        if ((k + i) >= int'(th1)) begin
          row[k+i] = x1[k] & y1[i];
        end
      end
      if (i < HALF) begin
        sum0_c = sum0_c + row;
      end else begin
        sum1_c = sum1_c + row;
      end
    end
  end

  always_comb begin
    comp_c = '0;
    if (COMP_EN && (th2 != '0)) begin
      comp_c[th2 - 1'b1] = 1'b1;
    end
    total_c = sum0 + sum1 + comp_c;
    z_c     = total_c[SW-1] ? '1 : total_c[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1          <= 1'b0;
      x1          <= '0;
      y1          <= '0;
      th1         <= '0;
      v2          <= 1'b0;
      sum0        <= '0;
      sum1        <= '0;
      th2         <= '0;
      out_valid_r <= 1'b0;
      z_r         <= '0;
      count_r     <= '0;
    end else begin
      if (en) begin
        v1          <= bus.in_valid;
        x1          <= bus.x;
        y1          <= bus.y;
        th1         <= bus.theta;
        v2          <= v1;
        sum0        <= sum0_c;
        sum1        <= sum1_c;
        th2         <= th1;
        out_valid_r <= v2;
        z_r         <= z_c;
      end
      if (out_valid_r && bus.out_ready) begin
        count_r <= count_r + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_column_approx_mult_pipe.sv
// Directed and random checks of the approximate multiplier pipe, with and without compensation.
// A column-count golden model feeds an in-order scoreboard for both instances.
module tb_column_approx_mult_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] x;
  logic [7:0] y;
  logic [3:0] theta;
  logic       out_ready;

  int total   = 0;
  int bad     = 0;
  int exp_cnt = 0;
  logic [15:0] q1[$];
  logic [15:0] q0[$];

  always #5 clk = ~clk;

  column_approx_mult_pipe_if #(.WIDTH(8)) bus1 ();
  column_approx_mult_pipe_if #(.WIDTH(8)) bus0 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.x         = x;
  assign bus1.y         = y;
  assign bus1.theta     = theta;
  assign bus1.out_ready = out_ready;
  assign bus0.in_valid  = in_valid;
  assign bus0.x         = x;
  assign bus0.y         = y;
  assign bus0.theta     = theta;
  assign bus0.out_ready = out_ready;

  column_approx_mult_pipe #(.WIDTH(8), .COMP_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  column_approx_mult_pipe #(.WIDTH(8), .COMP_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Golden model: count set partial-product bits per kept column.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] th, input bit ce);
    int t;
    int cnt;
    t = 0;
    for (int c = 0; c < 16; c++) begin
      if (c >= int'(th)) begin
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
          if ((c - i) >= 0 && (c - i) < 8) begin
            if (a[c-i] && b[i]) cnt++;
          end
        end
        t += cnt << c;
      end
    end
    if (ce && th != 4'd0) t += 1 << (int'(th) - 1);
    return (t > 65535) ? 16'hFFFF : 16'(t);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus1.out_valid && out_ready) begin
        exp_cnt++;
        chk("ov_match", bus0.out_valid, 1);
        if (q1.size() == 0) chk("sb_underrun1", q1.size(), 1);
        else chk("sb_z1", bus1.z, q1.pop_front());
        if (q0.size() == 0) chk("sb_underrun0", q0.size(), 1);
        else chk("sb_z0", bus0.z, q0.pop_front());
      end
      if (in_valid && bus1.in_ready) begin
        q1.push_back(model(x, y, theta, 1'b1));
        q0.push_back(model(x, y, theta, 1'b0));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    bit ok;
    ok = 1'b0;
    x = a; y = b; theta = t; in_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = bus1.in_ready;
      @(posedge clk); #1;
    end
    chk("send_acc", ok, 1);
  endtask

  task automatic wait_out();
    for (int n = 0; n < 20; n++) begin
      if (bus1.out_valid) break;
      @(posedge clk); #1;
    end
    chk("wait_ov", bus1.out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, rises, acc, idx;
    bit prev, took;
    logic [7:0] px [4];
    logic [7:0] py [4];
    logic [3:0] pt [4];
    px = '{8'd11, 8'd22, 8'd33, 8'd44};
    py = '{8'd200, 8'd177, 8'd5, 8'd250};
    pt = '{4'd3, 4'd0, 4'd6, 4'd9};

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; theta = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", bus1.out_valid, 0);
    chk("rst_z", bus1.z, 0);
    chk("rst_cnt", bus1.out_count, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back stream of six
    nv = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        x = 8'(10 + i*37); y = 8'(3 + i*41); theta = 4'(i*2); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (bus1.out_valid) nv++;
      if (bus1.out_valid && !prev) rises++;
      prev = bus1.out_valid;
    end
    chk("s4_n", nv, 6);
    chk("s4_runs", rises, 1);
    chk("s4_cnt", bus1.out_count, 6);

    // Exact product and three-cycle latency
    send(8'd200, 8'd150, 4'd0);
    in_valid = 1'b0;
    chk("t1_lat0", bus1.out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat1", bus1.out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat2", bus1.out_valid, 1);
    chk("t1_z1", bus1.z, 30000);
    chk("t1_z0", bus0.z, 30000);

    send(8'd255, 8'd255, 4'd8);
    in_valid = 1'b0;
    wait_out();
    chk("t2_z1", bus1.z, 63360);
    chk("t2_z0", bus0.z, 63232);

    send(8'd255, 8'd255, 4'd15);
    in_valid = 1'b0;
    wait_out();
    chk("t3_z1", bus1.z, 16384);
    chk("t3_z0", bus0.z, 0);
    @(posedge clk); #1;

    // Stall with four pending pairs
    out_ready = 1'b0; idx = 0; acc = 0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      x = px[idx]; y = py[idx]; theta = pt[idx];
      @(negedge clk);
      took = bus1.in_ready;
      @(posedge clk); #1;
      if (took) begin acc++; if (idx < 3) idx++; end
      if (cyc >= 3) begin
        chk("s5_z", bus1.z, model(px[0], py[0], pt[0], 1'b1));
        chk("s5_ir", bus1.in_ready, 0);
      end
    end
    chk("s5_acc", acc, 3);
    out_ready = 1'b1;
    send(px[3], py[3], pt[3]);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("s5_drain", q1.size(), 0);

    // Reset with two transactions in flight
    send(8'd77, 8'd99, 4'd2);
    send(8'd13, 8'd240, 4'd5);
    in_valid = 1'b0;
    rst = 1'b1;
    q1.delete(); q0.delete(); exp_cnt = 0;
    #1;
    chk("t6_ov", bus1.out_valid, 0);
    chk("t6_z", bus1.z, 0);
    chk("t6_cnt", bus1.out_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t6_stale", bus1.out_valid, 0);
    end
    send(8'd9, 8'd9, 4'd0);
    in_valid = 1'b0;
    wait_out();
    chk("t6_next", bus1.z, 81);
    @(posedge clk); #1;

    // Random traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      took = in_valid && bus1.in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 2) != 0);
        x = 8'($urandom);
        y = 8'($urandom);
        theta = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rnd_drain", q1.size(), 0);
    chk("cnt_final", bus1.out_count, 32'(exp_cnt[15:0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
